// File: rtl/event_filter_scheduler.sv
// event_filter_scheduler: round-robin arbiter that shares one event-denoising
// filter between N_REQ sources. It can drop events of the wrong polarity and
// inject WINDOW_SIZE zero events to flush the filter window.
module event_filter_scheduler #(
  parameter int         N_REQ       = 4,
  parameter int         WINDOW_SIZE = 4,
  parameter logic [1:0] POL_KEEP    = 2'b11
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] evt_in,
  output logic [N_REQ-1:0]   gnt,
  input  logic               pol_filter_en,
  input  logic               flush_req,
  output logic               flush_busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:0]         out_x,
  output logic [1:0]         out_y,
  output logic [1:0]         out_p,
  output logic [1:0]         out_t,
  output logic [2:0]         out_src,
  output logic [7:0]         drop_cnt
);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t     state, state_nxt;
  logic [2:0] ptr;
  logic       flush_pend;
  logic [3:0] flush_cnt;
  logic       free, flush_now, found, grant_ok, drop, last_acc;
  logic [2:0] winner;
  logic [7:0] win_evt;
  int         idx;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign free      = !out_valid || out_ready;
  assign flush_now = flush_pend || flush_req;
  assign last_acc  = (state == FLUSH) && out_ready && (flush_cnt == 4'(WINDOW_SIZE - 1));

  // Round-robin search starting just above the last winner, wrapping around.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = 3'(idx);
      end
    end
  end

  // Grant only when idle, the output register can take a value and no flush is due.
  always_comb begin
    grant_ok = reset_n && (state == IDLE) && free && !flush_now && found;
    win_evt  = evt_in[{winner, 3'b000} +: 8];
    drop     = pol_filter_en && (win_evt[3:2] != POL_KEEP);
    gnt      = grant_ok ? (N_REQ'(1) << winner) : '0;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic: flush starts when the output is free, ends on the last accept.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (free && flush_now) state_nxt = FLUSH;
      FLUSH:   if (last_acc)          state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output register, pointer, flush bookkeeping and drop counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr        <= 3'(N_REQ - 1);
      flush_pend <= 1'b0;
      flush_cnt  <= '0;
      flush_busy <= 1'b0;
      out_valid  <= 1'b0;
      out_x      <= '0;
      out_y      <= '0;
      out_p      <= '0;
      out_t      <= '0;
      out_src    <= '0;
      drop_cnt   <= '0;
    end else begin
      flush_pend <= flush_pend || flush_req;
      case (state)
        IDLE: begin
          if (free) begin
            if (flush_now) begin
              flush_pend <= 1'b0;
              flush_busy <= 1'b1;
              flush_cnt  <= '0;
              out_valid  <= 1'b1;
              {out_x, out_y, out_p, out_t} <= 8'h00;
              out_src    <= 3'b111;
            end else if (found) begin
              ptr <= winner;
              if (drop) begin
                out_valid <= 1'b0;
                drop_cnt  <= sat_inc8(drop_cnt);
              end else begin
                out_valid <= 1'b1;
                {out_x, out_y, out_p, out_t} <= win_evt;
                out_src   <= winner;
              end
            end else begin
              out_valid <= 1'b0;
            end
          end
        end
        FLUSH: begin
          if (out_ready) begin
            if (last_acc) begin
              out_valid  <= 1'b0;
              flush_busy <= 1'b0;
              flush_cnt  <= '0;
            end else begin
              flush_cnt <= flush_cnt + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
